// File: rtl/inst_encoder_pkg.sv
// Shared RV32I opcode constants, field bundle and packing helpers for the instruction encoder.
package inst_encoder_pkg;

    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_I     = 7'b0010011;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_JALR  = 7'b1100111;
    localparam logic [6:0]  OP_S     = 7'b0100011;
    localparam logic [6:0]  OP_B     = 7'b1100011;
    localparam logic [6:0]  OP_J     = 7'b1101111;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_J   = 3'd4,
        FMT_BAD = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    function automatic fmt_e op_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:                  f = FMT_R;
            OP_I, OP_LOAD, OP_JALR: f = FMT_I;
            OP_S:                  f = FMT_S;
            OP_B:                  f = FMT_B;
            OP_J:                  f = FMT_J;
            default:               f = FMT_BAD;
        endcase
        return f;
    endfunction

    // True when imm is representable as a two's-complement value of the given width.
    function automatic logic fits_signed(input logic [31:0] imm, input int unsigned width);
        logic [31:0] v;
        v = $signed(imm) >>> (width - 32'd1);
        return (v == 32'h0000_0000) || (v == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pack_inst(input fields_t f);
        logic [31:0] w;
        case (op_fmt(f.opcode))
            FMT_R:   w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I:   w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S:   w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B:   w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                          f.imm[4:1], f.imm[11], f.opcode};
            FMT_J:   w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_encoder_imm_range_check.sv
// Combinational immediate range/alignment check; unknown opcodes are always flagged.
module imm_range_check
    import inst_encoder_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [31:0] i_imm,
    output logic        o_err
);

    // Branch and jump offsets must also be halfword aligned.
    always_comb begin
        o_err = 1'b1;
        case (op_fmt(i_opcode))
            FMT_R:        o_err = 1'b0;
            FMT_I, FMT_S: o_err = ~fits_signed(i_imm, 32'd12);
            FMT_B:        o_err = ~fits_signed(i_imm, 32'd13) | i_imm[0];
            FMT_J:        o_err = ~fits_signed(i_imm, 32'd21) | i_imm[0];
            default:      o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction packer with valid/ready handshakes, address counter and error count.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [31:0] out_addr,
    input  logic        addr_load,
    input  logic [31:0] addr_base,
    output logic [7:0]  err_cnt
);

    logic        r_s1_valid;
    fields_t     r_s1_fields;
    logic        r_s1_err;
    logic        r_s2_valid;
    logic [31:0] r_s2_inst;
    logic        r_s2_err;
    logic [31:0] r_addr;
    logic [7:0]  r_err_cnt;

    logic        w_s2_adv;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_range_err;
    fields_t     w_in_fields;

    assign w_s2_adv   = ~r_s2_valid | out_ready;
    assign in_ready   = ~r_s1_valid | w_s2_adv;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_s2_valid & out_ready;

    assign w_in_fields = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                           funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    imm_range_check u_imm_chk (
        .i_opcode (in_opcode),
        .i_imm    (in_imm),
        .o_err    (w_range_err)
    );

    // Stage 1: capture raw fields and the range verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_fields <= '0;
            r_s1_err    <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid  <= 1'b1;
            r_s1_fields <= w_in_fields;
            r_s1_err    <= w_range_err;
        end else if (w_s2_adv) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // Stage 2: packed word, held while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_inst  <= 32'h0000_0000;
            r_s2_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_inst <= pack_inst(r_s1_fields);
                r_s2_err  <= r_s1_err;
            end
        end
    end

    // Address counter: a reload takes priority over the handshake increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= 32'h0000_0000;
        end else if (addr_load) begin
            r_addr <= addr_base;
        end else if (w_out_fire) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    // Saturating count of errored words actually delivered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_out_fire && r_s2_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_inst  = r_s2_inst;
    assign out_err   = r_s2_err;
    assign out_addr  = r_addr;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder with hand-computed instruction words.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [31:0] out_addr;
    logic        addr_load;
    logic [31:0] addr_base;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] stream_exp [4];

    inst_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .out_addr  (out_addr),
        .addr_load (addr_load),
        .addr_base (addr_base),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic send_one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] exp_inst, input logic exp_err,
                            input logic [31:0] exp_addr);
        set_fields(op, rd, rs1, rs2, f3, f7, imm);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_inst"}, out_inst, exp_inst);
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        check({tag, "_addr"}, out_addr, exp_addr);
        @(posedge clk); #1;
    endtask

    initial begin
        int tx;
        int rx;
        stream_exp[0] = 32'h0000_0093;
        stream_exp[1] = 32'h0100_0113;
        stream_exp[2] = 32'h0200_0193;
        stream_exp[3] = 32'h0300_0213;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        addr_load = 1'b0;
        addr_base = 32'h0000_0000;
        set_fields(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'h0000_0000);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_addr", out_addr, 32'h0000_0000);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send_one("addi5",   7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,          32'h0050_0093, 1'b0, 32'd0);
        send_one("beq_m4",  7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC,  32'hFE20_8EE3, 1'b0, 32'd4);
        send_one("beq_odd", 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,          32'h0020_8163, 1'b1, 32'd8);
        check("errcnt_1", 32'(err_cnt), 32'd1);
        send_one("jal2048", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h0010_00EF, 1'b0, 32'd12);
        send_one("addi_ov", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h8000_0093, 1'b1, 32'd16);
        send_one("badop",   7'b1111111, 5'd1, 5'd2, 5'd3, 3'd1, 7'h00, 32'd0,          32'h0000_0013, 1'b1, 32'd20);
        check("errcnt_3", 32'(err_cnt), 32'd3);
        send_one("sw_m8",   7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 32'hFFFF_FFF8,  32'hFE31_2C23, 1'b0, 32'd24);
        send_one("sub",     7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,          32'h4020_81B3, 1'b0, 32'd28);
        send_one("beq_max", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,       32'h7E00_0FE3, 1'b0, 32'd32);

        // Address reload coincident with a handshake.
        out_ready = 1'b0;
        set_fields(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("ld_valid", 32'(out_valid), 32'd1);
        check("ld_inst", out_inst, 32'h0010_0113);
        out_ready = 1'b1;
        addr_load = 1'b1;
        addr_base = 32'h0000_0100;
        #1;
        check("ld_old_addr", out_addr, 32'd36);
        @(posedge clk); #1;
        addr_load = 1'b0;
        check("ld_drained", 32'(out_valid), 32'd0);
        check("ld_new_addr", out_addr, 32'h0000_0100);
        send_one("after_ld", 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 32'h0020_0193, 1'b0, 32'h0000_0100);

        // Reset with two words in flight.
        out_ready = 1'b0;
        set_fields(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_addr", out_addr, 32'h0000_0000);
        check("mid_rst_inst", out_inst, 32'h0000_0000);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Stream of four words with the consumer stalled in cycles 2-4.
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (tx < 4);
            set_fields(7'b0010011, 5'(tx + 1), 5'd0, 5'd0, 3'd0, 7'h00, 32'(tx * 16));
            #1;
            if (cyc <= 5)
                check($sformatf("str_in_ready_c%0d", cyc), 32'(in_ready),
                      32'((cyc >= 2 && cyc <= 4) ? 0 : 1));
            if (out_valid) begin
                check($sformatf("str_inst_c%0d", cyc), out_inst, stream_exp[rx]);
                check($sformatf("str_addr_c%0d", cyc), out_addr, 32'(rx * 4));
                if (out_ready)
                    rx++;
            end
            if (in_valid && in_ready)
                tx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("str_all_out", 32'(rx), 32'd4);
        check("str_final_addr", out_addr, 32'd16);
        check("str_err_cnt", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
